// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the RAM burst arbiter: default bus widths, the
// memory beat size and the arbiter FSM state encoding.
// ----------------------------------------------------------------------------
package ram_arb_pkg;

   // Default widths: byte address, data bus, burst-length field (beats-1).
   localparam int DEF_ADDR_W = 30;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_LEN_W  = 8;

   // One bus beat moves this many bytes; the memory auto-increments by it.
   localparam int BEAT_BYTES = 8;
   localparam int ALIGN_BITS = $clog2(BEAT_BYTES);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2,
      GAP      = 2'd3
   } state_t;

endpackage : ram_arb_pkg

// File: rtl/ram_burst_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin decision. A lone request is granted outright; on a tie
// the client that was not served last wins.
//
// Ports:
//   i_req[1:0]  requests, bit 0 = write client, bit 1 = read client
//   i_last_rd   1 = read client was served last, 0 = write client
//   i_en        arbitration enable; grant is all-zero when low
//   o_grant     one-hot grant, same bit order as i_req
// ----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_rd,
   input  logic       i_en,
   output logic [1:0] o_grant
);

   always_comb begin
      // NOTE: default assignment first so every path drives o_grant and no latch is inferred.
      o_grant = 2'b00;
      if (i_en) begin
         unique case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_rd ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
         endcase
      end
   end

endmodule : rr_arb2

// File: rtl/ram_burst_arbiter.sv
// ----------------------------------------------------------------------------
// ram_burst_arbiter
// Arbitrates a write client and a read client onto one burst-oriented memory
// port. Each granted burst runs len+1 beats at a fixed, 8-byte-aligned base
// address (the memory increments internally), followed by one GAP cycle with
// both enables low so the memory's address increment restarts.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_len         write burst request, start address, beats-1
//   wr_grant                      1-cycle pulse: write request accepted
//   wr_data, wr_data_rden         FWFT write data and its consume strobe
//   wr_done                       1-cycle pulse in the GAP after a write burst
//   rd_req/rd_addr/rd_len         read burst request, start address, beats-1
//   rd_grant                      1-cycle pulse: read request accepted
//   rd_data, rd_data_valid        registered read beat and its valid
//   rd_done                       1-cycle pulse with the last rd_data_valid
//   mem_wr_en/mem_rd_en           memory burst enables (never both high)
//   mem_wr_addr/mem_rd_addr       memory base address, held for the burst
//   mem_data                      bidirectional memory data bus
//   busy                          a burst is granted or in progress
// ----------------------------------------------------------------------------
module ram_burst_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LEN_W-1:0]  wr_len,
   output logic              wr_grant,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_data_rden,
   output logic              wr_done,

   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [LEN_W-1:0]  rd_len,
   output logic              rd_grant,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   output logic              rd_done,

   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [ADDR_W-1:0] mem_rd_addr,
   inout  wire  [DATA_W-1:0] mem_data,

   output logic              busy
);

   state_t              r_state;
   logic [LEN_W-1:0]    r_beat_cnt;
   logic                r_last_rd;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_rd_valid;

   logic [1:0]          w_grant;
   logic                w_arb_en;
   logic                w_unused_addr_lsbs;

   // Arbitration only happens in IDLE and is held off while reset is applied,
   // so no grant pulse can leak out during reset.
   assign w_arb_en = (r_state == IDLE) && !rst;

   rr_arb2 u_rr_arb2 (
      .i_req     ({rd_req, wr_req}),
      .i_last_rd (r_last_rd),
      .i_en      (w_arb_en),
      .o_grant   (w_grant)
   );

   // The byte offset within a beat is discarded by alignment.
   assign w_unused_addr_lsbs = ^{wr_addr[ALIGN_BITS-1:0], rd_addr[ALIGN_BITS-1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_beat_cnt <= '0;
         r_last_rd  <= 1'b1;   // write wins the first tie after reset
         r_wr_addr  <= '0;
         r_rd_addr  <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // sees pre-edge values regardless of statement order.
         // Read data lands one cycle after its enable; this also makes the last
         // valid beat coincide with the GAP cycle.
         r_rd_valid <= (r_state == RD_BURST);
         if (r_state == RD_BURST) begin
            r_rd_data <= mem_data;
         end

         unique case (r_state)
            IDLE: begin
               if (w_grant[0]) begin
                  r_last_rd  <= 1'b0;
                  r_wr_addr  <= {wr_addr[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
                  r_beat_cnt <= wr_len;
                  r_state    <= WR_BURST;
               end else if (w_grant[1]) begin
                  r_last_rd  <= 1'b1;
                  r_rd_addr  <= {rd_addr[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
                  r_beat_cnt <= rd_len;
                  r_state    <= RD_BURST;
               end
            end
            WR_BURST, RD_BURST: begin
               // Counter holds beats remaining minus one, so len=0 gives one
               // beat and the all-ones length never needs an extra bit.
               if (r_beat_cnt == '0) begin
                  r_state <= GAP;
               end else begin
                  r_beat_cnt <= r_beat_cnt - 1'b1;
               end
            end
            GAP:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign wr_grant      = w_grant[0];
   assign rd_grant      = w_grant[1];

   assign mem_wr_en     = (r_state == WR_BURST);
   assign mem_rd_en     = (r_state == RD_BURST);
   assign wr_data_rden  = (r_state == WR_BURST);
   assign mem_wr_addr   = r_wr_addr;
   assign mem_rd_addr   = r_rd_addr;

   // r_last_rd was updated at grant, so in GAP it names the burst just ended.
   assign wr_done       = (r_state == GAP) && !r_last_rd;
   assign rd_done       = (r_state == GAP) &&  r_last_rd;

   assign rd_data       = r_rd_data;
   assign rd_data_valid = r_rd_valid;

   // Busy covers the grant cycle through GAP.
   assign busy          = (r_state != IDLE) || (w_grant != 2'b00);

   assign mem_data      = mem_wr_en ? wr_data : {DATA_W{1'bz}};

endmodule : ram_burst_arbiter

// File: tb/tb_ram_burst_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_burst_arbiter
// Self-checking bench: vector table, hand-written reset/hold sequences and a
// randomized phase checked against a high-level model (round-robin by
// "who was served last", expected memory contents as an array).
// ----------------------------------------------------------------------------
module tb_ram_burst_arbiter;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 64;
   localparam int LEN_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_req, rd_req;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [LEN_W-1:0]  wr_len, rd_len;
   logic              wr_grant, rd_grant, wr_data_rden, wr_done;
   logic              rd_data_valid, rd_done, mem_wr_en, mem_rd_en, busy;
   logic [DATA_W-1:0] wr_data, rd_data;
   logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
   wire  [DATA_W-1:0] mem_data;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   ram_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_req        (wr_req),
      .wr_addr       (wr_addr),
      .wr_len        (wr_len),
      .wr_grant      (wr_grant),
      .wr_data       (wr_data),
      .wr_data_rden  (wr_data_rden),
      .wr_done       (wr_done),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_len        (rd_len),
      .rd_grant      (rd_grant),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .rd_done       (rd_done),
      .mem_wr_en     (mem_wr_en),
      .mem_rd_en     (mem_rd_en),
      .mem_wr_addr   (mem_wr_addr),
      .mem_rd_addr   (mem_rd_addr),
      .mem_data      (mem_data),
      .busy          (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int idx(input logic [ADDR_W-1:0] a, input int beat);
      return (int'(a >> 3) + beat) % 1024;
   endfunction

   // ---------------- write source (FWFT): word = {tag, beat index} ----------
   logic [31:0] wr_tag = 32'h0;
   int          wr_idx;
   assign wr_data = {wr_tag, 32'(wr_idx)};
   always @(posedge clk or posedge rst) begin
      if (rst)               wr_idx <= 0;
      else if (wr_grant)     wr_idx <= 0;
      else if (wr_data_rden) wr_idx <= wr_idx + 1;
   end

   // ---------------- memory device: auto-increments 8 bytes per beat --------
   logic [63:0] mem_array [0:1023] = '{default: 64'h0};
   logic [63:0] exp_mem   [0:1023] = '{default: 64'h0};
   int          mem_wbeat = 0;
   int          mem_rbeat = 0;
   logic [63:0] mem_rd_word;

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem_array[idx(mem_wr_addr, mem_wbeat)] <= mem_data;
         mem_wbeat <= mem_wbeat + 1;
      end else begin
         mem_wbeat <= 0;
      end
      if (mem_rd_en) mem_rbeat <= mem_rbeat + 1;
      else           mem_rbeat <= 0;
   end

   always_comb mem_rd_word = mem_array[idx(mem_rd_addr, mem_rbeat)];
   assign mem_data = mem_rd_en ? mem_rd_word : {DATA_W{1'bz}};

   // ---------------- per-cycle bus monitor ----------------------------------
   always @(negedge clk) begin
      check("enable overlap", 64'(mem_wr_en & mem_rd_en), 64'd0);
      if (mem_wr_en || mem_rd_en) check("bus unknown", 64'($isunknown(mem_data)), 64'd0);
      else                        check("bus released", 64'(mem_data === {DATA_W{1'bz}}), 64'd1);
   end

   // ---------------- reference model state ----------------------------------
   bit model_last_rd = 1'b1;

   // One burst from an IDLE negedge: returns at the IDLE negedge after GAP.
   task automatic run_txn(input bit wq, input bit rq,
                          input logic [ADDR_W-1:0] wa, input logic [LEN_W-1:0] wl,
                          input logic [ADDR_W-1:0] ra, input logic [LEN_W-1:0] rl,
                          input bit hold, input bit exp_rd,
                          input logic [ADDR_W-1:0] exp_base, input string tag);
      int   beats, n_en, n_busy, n_valid, cyc, bad;
      bit   prev_rd, gap, en;
      logic [31:0] tag_used;
      beats   = exp_rd ? int'(rl) + 1 : int'(wl) + 1;
      n_en = 0; n_busy = 0; n_valid = 0; cyc = 0; bad = 0;
      prev_rd = 1'b0; gap = 1'b0;
      tag_used = $urandom;
      wr_tag  = tag_used;
      wr_req  = wq;  rd_req = rq;
      wr_addr = wa;  wr_len = wl;
      rd_addr = ra;  rd_len = rl;
      #1;
      check({tag, " wr_grant"}, 64'(wr_grant), 64'(!exp_rd));
      check({tag, " rd_grant"}, 64'(rd_grant), 64'(exp_rd));
      if (busy) n_busy++;
      model_last_rd = exp_rd;
      while (!gap && cyc < 400) begin
         @(posedge clk); #1;
         if (!hold) begin
            wr_req = 1'b0; rd_req = 1'b0;
            wr_addr = ADDR_W'($urandom); rd_addr = ADDR_W'($urandom);
            wr_len  = LEN_W'($urandom);  rd_len  = LEN_W'($urandom);
         end
         @(negedge clk);
         cyc++;
         if (busy) n_busy++;
         en = exp_rd ? mem_rd_en : mem_wr_en;
         if (exp_rd) begin
            check({tag, " valid follows rd_en"}, 64'(rd_data_valid), 64'(prev_rd));
            if (rd_data_valid) begin
               check({tag, " rd_data"}, rd_data, exp_mem[idx(exp_base, n_valid)]);
               n_valid++;
            end
            prev_rd = mem_rd_en;
         end
         if (en) begin
            n_en++;
            check({tag, " base addr"}, 64'(exp_rd ? mem_rd_addr : mem_wr_addr), 64'(exp_base));
            if (!exp_rd) check({tag, " wr_data_rden"}, 64'(wr_data_rden), 64'd1);
            check({tag, " done early"}, 64'(wr_done | rd_done), 64'd0);
         end else begin
            gap = 1'b1;
            check({tag, " wr_done"}, 64'(wr_done), 64'(!exp_rd));
            check({tag, " rd_done"}, 64'(rd_done), 64'(exp_rd));
         end
      end
      check({tag, " burst ended"}, 64'(gap), 64'd1);
      check({tag, " beats"}, 64'(n_en), 64'(beats));
      check({tag, " busy cycles"}, 64'(n_busy), 64'(beats + 2));
      if (exp_rd) begin
         check({tag, " valid beats"}, 64'(n_valid), 64'(beats));
      end else begin
         for (int i = 0; i < beats; i++) begin
            exp_mem[idx(exp_base, i)] = {tag_used, 32'(i)};
            if (mem_array[idx(exp_base, i)] !== {tag_used, 32'(i)}) bad++;
         end
         check({tag, " memory words wrong"}, 64'(bad), 64'd0);
      end
      @(negedge clk);
      if (!hold) check({tag, " busy after gap"}, 64'(busy), 64'd0);
      check({tag, " done is one pulse"}, 64'(wr_done | rd_done), 64'd0);
   endtask

   typedef struct {
      bit              wq;
      bit              rq;
      logic [ADDR_W-1:0] wa;
      logic [LEN_W-1:0]  wl;
      logic [ADDR_W-1:0] ra;
      logic [LEN_W-1:0]  rl;
      bit              exp_rd;
      logic [ADDR_W-1:0] exp_base;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cyc, n_en;
      bit wq, rq, exp_rd;
      logic [ADDR_W-1:0] wa, ra;
      logic [LEN_W-1:0]  wl, rl;

      vecs[0] = '{1'b1, 1'b0, 30'h100, 8'd3,   30'h0,   8'd0, 1'b0, 30'h100};
      vecs[1] = '{1'b0, 1'b1, 30'h0,   8'd0,   30'h100, 8'd3, 1'b1, 30'h100};
      vecs[2] = '{1'b1, 1'b0, 30'h10D, 8'd0,   30'h0,   8'd0, 1'b0, 30'h108};
      vecs[3] = '{1'b0, 1'b1, 30'h0,   8'd0,   30'h10F, 8'd0, 1'b1, 30'h108};
      vecs[4] = '{1'b1, 1'b1, 30'h200, 8'd1,   30'h100, 8'd2, 1'b0, 30'h200};
      vecs[5] = '{1'b1, 1'b1, 30'h300, 8'd0,   30'h100, 8'd2, 1'b1, 30'h100};
      vecs[6] = '{1'b1, 1'b0, 30'h400, 8'd255, 30'h0,   8'd0, 1'b0, 30'h400};
      vecs[7] = '{1'b0, 1'b1, 30'h0,   8'd0,   30'h400, 8'd255, 1'b1, 30'h400};

      rst = 1'b1;
      wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
      repeat (2) @(negedge clk);
      check("reset busy",      64'(busy), 64'd0);
      check("reset enables",   64'({mem_wr_en, mem_rd_en}), 64'd0);
      check("reset rd_valid",  64'(rd_data_valid), 64'd0);
      check("reset rd_data",   rd_data, 64'd0);
      check("reset dones",     64'({wr_done, rd_done}), 64'd0);
      check("reset wr addr",   64'(mem_wr_addr), 64'd0);
      rst = 1'b0;
      model_last_rd = 1'b1;
      @(negedge clk);

      // ---------------- table-driven bursts ----------------
      foreach (vecs[i]) begin
         run_txn(vecs[i].wq, vecs[i].rq, vecs[i].wa, vecs[i].wl, vecs[i].ra, vecs[i].rl,
                 1'b0, vecs[i].exp_rd, vecs[i].exp_base, $sformatf("vec%0d", i));
      end

      // ---------------- request dropped before IDLE sampling edge ----------
      wr_req = 1'b1; #1; wr_req = 1'b0;
      @(negedge clk);
      check("dropped req ignored", 64'({busy, mem_wr_en}), 64'd0);

      // ---------------- reset on the 3rd beat of a 256-beat write -----------
      wr_tag = 32'hBAD0_0001;
      wr_req = 1'b1; wr_addr = 30'h0; wr_len = 8'd255;
      #1;
      check("long wr grant", 64'(wr_grant), 64'd1);
      @(posedge clk); #1;
      wr_req = 1'b0;
      n_en = 0; wait_cyc = 0;
      while (n_en < 3 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
         if (mem_wr_en) n_en++;
      end
      check("reached 3rd beat", 64'(n_en), 64'd3);
      rst = 1'b1;
      #1;
      check("rst mem_wr_en",    64'(mem_wr_en), 64'd0);
      check("rst rden",         64'(wr_data_rden), 64'd0);
      check("rst bus high-z",   64'(mem_data === {DATA_W{1'bz}}), 64'd1);
      check("rst busy",         64'(busy), 64'd0);
      check("rst no wr_done",   64'(wr_done), 64'd0);
      @(negedge clk);
      check("rst hold no done", 64'(wr_done), 64'd0);
      rst = 1'b0;
      model_last_rd = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post-rst no done", 64'({wr_done, busy}), 64'd0);
      end
      run_txn(1'b0, 1'b1, 30'h0, 8'd0, 30'h108, 8'd0, 1'b0, 1'b1, 30'h108, "post-rst read");

      // ---------------- both held high for three rounds after reset --------
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_last_rd = 1'b1;
      @(negedge clk);
      run_txn(1'b1, 1'b1, 30'h700, 8'd2, 30'h400, 8'd1, 1'b1, 1'b0, 30'h700, "hold r1");
      run_txn(1'b1, 1'b1, 30'h700, 8'd2, 30'h400, 8'd1, 1'b1, 1'b1, 30'h400, "hold r2");
      run_txn(1'b1, 1'b1, 30'h708, 8'd2, 30'h400, 8'd1, 1'b0, 1'b0, 30'h708, "hold r3");

      // ---------------- randomized bursts vs. model ----------------
      for (int k = 0; k < 40; k++) begin
         wq = 1'($urandom);
         rq = 1'($urandom);
         if (!wq && !rq) wq = 1'b1;
         wa = 30'h400 + ADDR_W'($urandom_range(0, 30'hBFF));
         ra = 30'h400 + ADDR_W'($urandom_range(0, 30'hBFF));
         wl = LEN_W'($urandom_range(0, 15));
         rl = LEN_W'($urandom_range(0, 15));
         // Round-robin: lone request wins; a tie goes to whoever was not served last.
         exp_rd = (wq && rq) ? !model_last_rd : rq;
         run_txn(wq, rq, wa, wl, ra, rl, 1'b0, exp_rd,
                 exp_rd ? (ra - (ra % 8)) : (wa - (wa % 8)), $sformatf("rand%0d", k));
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("idle between", 64'(busy), 64'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule : tb_ram_burst_arbiter
